uart_rx_packer: RTL and testbench
=================================

# uart_rx_packer

Receive-side companion to the UART transmit controller. Takes the byte stream from the UART receiver, packs every four bytes (first byte = MSB) into a 32-bit word and writes it into the command/data FIFO through a single-word holding register. An inter-byte timeout drops partial words. Sticky status flags report dropped data to the host-side logic.

## Interface
Parameters:
- TIMEOUT_CYC, 24'd500000: consecutive idle Clk cycles (RxValid low) after which a partial word is discarded; legal range 2..2^24-1.

Ports:
- Clk  in  1  system clock; every register updates on its rising edge.
- Rst  in  1  reset, synchronous, active-high.
- RxValid  in  1  one-cycle strobe; RxData holds a received byte.
- RxData  in  8  received byte.
- FIFOFul  in  1  FIFO full; no write is issued while it is high.
- WrReq  out  1  one-cycle FIFO write strobe.
- D  out  32  FIFO write data; stable during WrReq.
- Overrun  out  1  sticky: a completed word was dropped because the hold register was occupied.
- FrameErr  out  1  sticky: a partial word was discarded by the timeout.
- ErrClr  in  1  clears Overrun and FrameErr.
- WordCnt  out  16  count of words written (WrReq pulses); wraps 0xFFFF -> 0.

## Operation
- Reset values: WrReq=0, D=0, Overrun=0, FrameErr=0, WordCnt=0. Internally ByteCnt=0, Hold=0, HoldVld=0, idle counter=0.
- Assembler FSM has two states:
  - A_IDLE (ByteCnt=0).
  - A_COLLECT (1..3 bytes held). Each accepted byte shifts in: Shift <= {Shift[23:0], RxData}, and ByteCnt increments.
  - On the 4th byte the completed word {Shift[23:0], RxData} goes to Hold. ByteCnt returns to 0 and the FSM returns to A_IDLE.
- Write FSM has two states:
  - W_EMPTY (HoldVld=0).
  - W_HELD (HoldVld=1). Each cycle in W_HELD with FIFOFul=0: D <= Hold, WrReq <= 1, HoldVld <= 0, WordCnt <= WordCnt+1.
  - WrReq is 0 in every other cycle.
- Word completion while HoldVld=1:
  - If the hold register is not being released at the same edge, the new word is dropped and Overrun is set. Hold keeps the older word.
  - If it is being released at the same edge, the new word loads Hold, HoldVld stays 1, and no error is raised.
- Timeout:
  - The idle counter clears on every RxValid and increments otherwise. It saturates at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC in A_COLLECT: discard the partial word, ByteCnt <= 0, set FrameErr.
  - No effect in A_IDLE.
  - If RxValid is high in the expiry cycle, the byte is accepted and no timeout occurs.
- ErrClr: clears both flags. If an error event happens in the same cycle, the set wins.
- Rst mid-word or mid-write: all state returns to reset values. The partial word and the held word are lost, and no WrReq is issued.

## Timing
- Byte with RxValid in cycle N:
  - Shift/ByteCnt update at the end of cycle N.
  - If it is the 4th byte, HoldVld=1 in cycle N+1.
  - If FIFOFul=0 in cycle N+1, WrReq=1 and D is valid in cycle N+2. Minimum latency is 2 cycles.
- When FIFOFul is high, WrReq is asserted in the cycle after the first cycle in which FIFOFul is sampled low.
- RxValid every cycle is sustained indefinitely with FIFOFul=0; at most one word is outstanding in Hold.
- WrReq is never asserted in two consecutive cycles except for back-to-back held words.

## Structure
- Shared package holds:
  - BYTES_PER_WORD=4.
  - Assembler state encodings A_IDLE/A_COLLECT.
  - Write state encodings W_EMPTY/W_HELD.
  - Status bit indices used when Overrun and FrameErr are mapped into the host status register.
- One sub-module, uart_rx_timer: the idle counter with a clear/enable input and a TIMEOUT_CYC parameter. It outputs a one-cycle Expire pulse.

## Test plan
- Bytes 0x12,0x34,0x56,0x78 at 10-cycle spacing, FIFOFul=0 -> a single WrReq, D=0x12345678, 2 cycles after the last RxValid; WordCnt=1; no flags.
- Hold FIFOFul=1, send 0xDE,0xAD,0xBE,0xEF -> no WrReq. Drop FIFOFul in cycle K -> WrReq in K+1 with D=0xDEADBEEF.
- FIFOFul=1, send 8 bytes 0x01..0x08 -> Overrun=1. Release FIFOFul -> exactly one WrReq with D=0x01020304. Pulse ErrClr -> Overrun=0.
- TIMEOUT_CYC=100: send 0x11,0x22, then idle 100 cycles -> FrameErr=1, no WrReq. Send 0xAA,0xBB,0xCC,0xDD -> D=0xAABBCCDD. Repeat with RxValid exactly at cycle 100 -> no FrameErr.
- RxValid every cycle, 8 bytes 0xA0..0xA7, FIFOFul=0 -> two WrReq pulses with D=0xA0A1A2A3 then 0xA4A5A6A7; Overrun=0; WordCnt=2.
- Rst pulsed after 3 bytes, then 0x55,0x66,0x77,0x88 -> all outputs at reset values during Rst; single word D=0x55667788; WordCnt=1.

Source files
------------

// File: rtl/uart_rx_packer_pkg.sv
// Shared definitions for the UART receive-side word packer.
package uart_rx_packer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    A_IDLE    = 1'b0,
    A_COLLECT = 1'b1
  } asm_state_t;

  typedef enum logic {
    W_EMPTY = 1'b0,
    W_HELD  = 1'b1
  } wr_state_t;

  // Bit positions of the sticky flags in the host status register.
  localparam int STAT_OVERRUN_BIT  = 0;
  localparam int STAT_FRAMEERR_BIT = 1;

endpackage

// File: rtl/uart_rx_packer_timer.sv
// Inter-byte idle counter: cleared by every received byte, counts idle cycles,
// saturates at TIMEOUT_CYC and pulses Expire in the cycle it would reach it.
module uart_rx_timer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  output logic Expire
);

  logic [23:0] cnt;

  // Expire marks the TIMEOUT_CYC-th consecutive idle cycle; a byte in that
  // cycle suppresses it.
  assign Expire = !Clr && (cnt == TIMEOUT_CYC - 24'd1);

  // Idle counter: clear on activity, count up otherwise, hold at the limit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (Clr) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT_CYC) begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received bytes MSB-first into 32-bit words and hands them to the
// FIFO through a one-word hold register. Partial words are dropped after an
// inter-byte timeout; dropped data is reported through sticky flags.
//
// state     | meaning
// A_IDLE    | no byte of the current word received yet
// A_COLLECT | 1..3 bytes shifted in, waiting for the rest
// W_EMPTY   | hold register free
// W_HELD    | hold register has a word waiting for FIFO space
module uart_rx_packer
  import uart_rx_packer_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RxValid,
  input  logic [7:0]  RxData,
  input  logic        FIFOFul,
  output logic        WrReq,
  output logic [31:0] D,
  output logic        Overrun,
  output logic        FrameErr,
  input  logic        ErrClr,
  output logic [15:0] WordCnt
);

  asm_state_t  asm_state;
  wr_state_t   wr_state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] hold;
  logic [31:0] new_word;
  logic        hold_vld;
  logic        word_done;
  logic        release_hold;
  logic        timeout_drop;
  logic        overrun_evt;
  logic        expire;

  assign hold_vld     = (wr_state == W_HELD);
  assign word_done    = RxValid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign new_word     = {shift, RxData};
  assign release_hold = hold_vld && !FIFOFul;
  assign timeout_drop = expire && (asm_state == A_COLLECT);
  // A finished word is lost only when the hold register stays occupied.
  assign overrun_evt  = word_done && hold_vld && FIFOFul;

  uart_rx_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clr    (RxValid),
    .Expire (expire)
  );

  // Assembler: shift bytes in, wrap after the fourth, discard on timeout.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      asm_state <= A_IDLE;
      byte_cnt  <= '0;
      shift     <= '0;
    end else if (RxValid) begin
      shift <= new_word[23:0];
      if (word_done) begin
        byte_cnt  <= '0;
        asm_state <= A_IDLE;
      end else begin
        byte_cnt  <= byte_cnt + 2'd1;
        asm_state <= A_COLLECT;
      end
    end else if (timeout_drop) begin
      byte_cnt  <= '0;
      shift     <= '0;
      asm_state <= A_IDLE;
    end
  end

  // Write side: hold one word, write it the cycle after FIFO space is seen.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_state <= W_EMPTY;
      hold     <= '0;
      D        <= '0;
      WrReq    <= 1'b0;
      WordCnt  <= '0;
    end else begin
      WrReq <= 1'b0;
      case (wr_state)
        W_EMPTY: begin
          if (word_done) begin
            hold     <= new_word;
            wr_state <= W_HELD;
          end
        end
        W_HELD: begin
          if (!FIFOFul) begin
            D       <= hold;
            WrReq   <= 1'b1;
            WordCnt <= WordCnt + 16'd1;
            // Release and refill at the same edge keeps the register busy.
            if (word_done) begin
              hold <= new_word;
            end else begin
              wr_state <= W_EMPTY;
            end
          end
        end
        default: wr_state <= W_EMPTY;
      endcase
    end
  end

  // Sticky error flags: a new event in the clear cycle keeps the flag set.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Overrun  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      Overrun  <= overrun_evt  || (Overrun  && !ErrClr);
      FrameErr <= timeout_drop || (FrameErr && !ErrClr);
    end
  end

  logic unused_release;
  assign unused_release = release_hold;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer with a short timeout.
module tb_uart_rx_packer;
  import uart_rx_packer_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RxValid;
  logic [7:0]  RxData;
  logic        FIFOFul;
  logic        ErrClr;
  logic        WrReq;
  logic [31:0] D;
  logic        Overrun;
  logic        FrameErr;
  logic [15:0] WordCnt;

  int checks  = 0;
  int errors  = 0;
  int wr_seen = 0;
  int w0;
  logic [31:0] exp_q[$];

  uart_rx_packer #(
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RxValid  (RxValid),
    .RxData   (RxData),
    .FIFOFul  (FIFOFul),
    .WrReq    (WrReq),
    .D        (D),
    .Overrun  (Overrun),
    .FrameErr (FrameErr),
    .ErrClr   (ErrClr),
    .WordCnt  (WordCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic ovr, input logic ferr);
    logic [1:0] st;
    logic [1:0] ex;
    st = '0;
    ex = '0;
    st[STAT_OVERRUN_BIT]  = Overrun;
    st[STAT_FRAMEERR_BIT] = FrameErr;
    ex[STAT_OVERRUN_BIT]  = ovr;
    ex[STAT_FRAMEERR_BIT] = ferr;
    check(name, {30'd0, st}, {30'd0, ex});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxValid = 1'b1;
    RxData  = b;
    tick();
    RxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge Clk) begin
    if (!Rst && WrReq) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wrreq got D=%h want no write", D);
      end else begin
        check("wr_data", D, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; RxValid = 1'b0; RxData = '0; FIFOFul = 1'b0; ErrClr = 1'b0;
    idle(3);
    check("rst_wrreq", WrReq, 0);
    check("rst_d", D, 0);
    check("rst_wordcnt", WordCnt, 0);
    check_flags("rst_flags", 1'b0, 1'b0);
    Rst = 1'b0;
    tick();

    // Spaced bytes, free FIFO: write two cycles after the last byte.
    exp_q.push_back(32'h12345678);
    send_byte(8'h12); idle(9);
    send_byte(8'h34); idle(9);
    send_byte(8'h56); idle(9);
    send_byte(8'h78);
    check("t1_wrreq_n1", WrReq, 0);
    tick();
    check("t1_wrreq_n2", WrReq, 1);
    check("t1_d", D, 32'h12345678);
    check("t1_wordcnt", WordCnt, 1);
    tick();
    check("t1_wrreq_n3", WrReq, 0);
    check_flags("t1_flags", 1'b0, 1'b0);

    // FIFO full: word waits, written the cycle after FIFOFul drops.
    FIFOFul = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    w0 = wr_seen;
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle(5);
    check("t2_no_write", wr_seen, w0);
    FIFOFul = 1'b0;
    check("t2_wrreq_k", WrReq, 0);
    tick();
    check("t2_wrreq_k1", WrReq, 1);
    check("t2_d", D, 32'hDEADBEEF);
    tick();
    check("t2_wordcnt", WordCnt, 2);

    // Second word completes while the first is stuck: overrun.
    FIFOFul = 1'b1;
    exp_q.push_back(32'h01020304);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check_flags("t3_overrun", 1'b1, 1'b0);
    w0 = wr_seen;
    FIFOFul = 1'b0;
    idle(5);
    check("t3_one_write", wr_seen, w0 + 1);
    check("t3_wordcnt", WordCnt, 3);
    check_flags("t3_sticky", 1'b1, 1'b0);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    check_flags("t3_cleared", 1'b0, 1'b0);

    // Timeout after two bytes discards them.
    w0 = wr_seen;
    send_byte(8'h11); send_byte(8'h22);
    idle(99);
    check_flags("t4_before_expiry", 1'b0, 1'b0);
    idle(1);
    check_flags("t4_frameerr", 1'b0, 1'b1);
    check("t4_no_write", wr_seen, w0);
    exp_q.push_back(32'hAABBCCDD);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    idle(3);
    check("t4_wordcnt", WordCnt, 4);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    check_flags("t4_cleared", 1'b0, 1'b0);

    // Byte arriving exactly in the expiry cycle is kept.
    exp_q.push_back(32'h11223344);
    send_byte(8'h11); send_byte(8'h22);
    idle(99);
    send_byte(8'h33); send_byte(8'h44);
    idle(3);
    check_flags("t4b_no_frameerr", 1'b0, 1'b0);
    check("t4b_wordcnt", WordCnt, 5);

    // Back-to-back bytes: two words, no overrun.
    w0 = wr_seen;
    exp_q.push_back(32'hA0A1A2A3);
    exp_q.push_back(32'hA4A5A6A7);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    idle(4);
    check("t5_two_writes", wr_seen, w0 + 2);
    check("t5_wordcnt", WordCnt, 7);
    check_flags("t5_flags", 1'b0, 1'b0);

    // Reset with a held word, an overrun and a partial word pending.
    FIFOFul = 1'b1;
    for (int i = 1; i <= 8; i++) send_byte(8'hC0 + 8'(i));
    check_flags("t6_pre_overrun", 1'b1, 1'b0);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    Rst = 1'b1;
    FIFOFul = 1'b0;
    tick();
    check("t6_rst_wrreq", WrReq, 0);
    check("t6_rst_d", D, 0);
    check("t6_rst_wordcnt", WordCnt, 0);
    check_flags("t6_rst_flags", 1'b0, 1'b0);
    tick();
    check("t6_rst_wrreq2", WrReq, 0);
    Rst = 1'b0;
    w0 = wr_seen;
    exp_q.push_back(32'h55667788);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    idle(4);
    check("t6_one_write", wr_seen, w0 + 1);
    check("t6_wordcnt", WordCnt, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
